// File: rtl/sim_step_scheduler.sv
// sim_step_scheduler: paces generation updates of the 8x8x8 cell simulator.
// Free-runs at a switch-selected rate, single-steps from a button while
// stopped, and hands each generation to the datapath over a req/ack
// handshake. It also counts the completed generations.
module sim_step_scheduler #(
    parameter int unsigned BASE_PERIOD = 1562500, // clocks per step at Rate=0, >= 2
    parameter int unsigned CNT_W       = 24,      // must hold BASE_PERIOD << 3
    parameter int unsigned GEN_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,    // asynchronous, active-low
    input  logic             Run,      // async switch: 1 = free-run
    input  logic             StepBtn,  // async button: single-step when stopped
    input  logic [1:0]       Rate,     // period = BASE_PERIOD << Rate
    input  logic             Clear,    // synchronous abort, zeroes counters
    output logic             StepReq,
    input  logic             StepAck,
    output logic             Running,
    output logic [GEN_W-1:0] Gen,
    output logic             Overrun
);

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_RUN  = 2'd1,
        S_REQ  = 2'd2
    } state_t;

    // Synchronizer and edge-detect state.
    logic [1:0]       run_sync_q;
    logic [1:0]       btn_sync_q;
    logic             btn_prev_q;
    logic             run_s;
    logic             btn_s;
    logic             btn_rise;

    // Rate tick counter.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_m1;
    logic             counting;
    logic             tick;

    // FSM state and registered outputs.
    state_t           state_q;
    logic             single_q;
    logic             req_q;
    logic             running_q;
    logic [GEN_W-1:0] gen_q;
    logic             overrun_q;

    assign run_s    = run_sync_q[1];
    assign btn_s    = btn_sync_q[1];
    assign btn_rise = btn_s & ~btn_prev_q;

    // Two-flop synchronizers for the switch and button, plus the button
    // edge detector. Clear deliberately leaves these alone.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_sync_q <= '0;
            btn_sync_q <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            // NOTE: clocked state always uses non-blocking assignments so
            // every flop samples the pre-edge value of its neighbours; a
            // blocking assignment here would collapse the two-flop chain.
            run_sync_q <= {run_sync_q[0], Run};
            btn_sync_q <= {btn_sync_q[0], StepBtn};
            btn_prev_q <= btn_s;
        end
    end

    // Step period for the current Rate. The compare uses >= so that a
    // Rate decrease mid-count fires on the very next cycle instead of
    // waiting for the counter to wrap.
    assign period    = CNT_W'(BASE_PERIOD) << Rate;
    assign period_m1 = period - CNT_W'(1);
    assign counting  = run_s && ((state_q == S_RUN) || (state_q == S_REQ));
    assign tick      = counting && (cnt_q >= period_m1);

    // Next value of the tick counter: zeroed when stopped or cleared,
    // frozen when Run has dropped but the FSM has not yet left.
    always_comb begin
        // NOTE: combinational blocks assign a default first so no path
        // leaves cnt_d unassigned, which would otherwise infer a latch.
        cnt_d = cnt_q;
        if (Clear || (state_q == S_STOP)) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Step sequencer with registered handshake, Running, Gen and Overrun.
    // Clear outranks everything, including a coincident StepAck.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_STOP;
            single_q  <= 1'b0;
            req_q     <= 1'b0;
            running_q <= 1'b0;
            gen_q     <= '0;
            overrun_q <= 1'b0;
        end else if (Clear) begin
            state_q   <= S_STOP;
            single_q  <= 1'b0;
            req_q     <= 1'b0;
            running_q <= 1'b0;
            gen_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            // A rate tick while a request is still outstanding is dropped
            // and only flagged; the datapath is too slow for this Rate.
            if (tick && (state_q == S_REQ)) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                S_STOP: begin
                    if (run_s) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end else if (btn_rise) begin
                        state_q   <= S_REQ;
                        single_q  <= 1'b1;
                        req_q     <= 1'b1;
                        running_q <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (!run_s) begin
                        state_q   <= S_STOP;
                        running_q <= 1'b0;
                    end else if (tick) begin
                        state_q   <= S_REQ;
                        single_q  <= 1'b0;
                        req_q     <= 1'b1;
                        running_q <= 1'b1;
                    end
                end

                S_REQ: begin
                    // The request is never abandoned: whatever Run does,
                    // we wait for the ack before choosing where to go.
                    if (StepAck) begin
                        req_q <= 1'b0;
                        gen_q <= gen_q + GEN_W'(1);
                        if (!single_q && run_s) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end else begin
                            state_q   <= S_STOP;
                            running_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q   <= S_STOP;
                    single_q  <= 1'b0;
                    req_q     <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign StepReq = req_q;
    assign Running = running_q;
    assign Gen     = gen_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Directed testbench for sim_step_scheduler with a short BASE_PERIOD.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_sim_step_scheduler;

    localparam int BP = 4;
    localparam int CW = 8;
    localparam int GW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Run;
    logic          StepBtn;
    logic [1:0]    Rate;
    logic          Clear;
    logic          StepReq;
    logic          StepAck;
    logic          Running;
    logic [GW-1:0] Gen;
    logic          Overrun;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_req = 1'b0;
    logic cur_req  = 1'b0;
    logic auto_ack = 1'b0;

    always #5 Clk = ~Clk;

    sim_step_scheduler #(
        .BASE_PERIOD(BP),
        .CNT_W      (CW),
        .GEN_W      (GW)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Run    (Run),
        .StepBtn(StepBtn),
        .Rate   (Rate),
        .Clear  (Clear),
        .StepReq(StepReq),
        .StepAck(StepAck),
        .Running(Running),
        .Gen    (Gen),
        .Overrun(Overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance past the edge, record StepReq history and, when
    // enabled, acknowledge with StepReq delayed by one cycle.
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        prev_req = cur_req;
        cur_req  = StepReq;
        if (auto_ack) StepAck = prev_req;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rise(input string tag, input int bound, output int at);
        logic found;
        found = 1'b0;
        at    = cyc;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            if (cur_req && !prev_req) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_fall(input string tag, input int bound, output int at);
        logic found;
        found = 1'b0;
        at    = cyc;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            if (!cur_req && prev_req) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t0, r0, r1, r2, r3, r4, r5, r6, r7, rb, f, c0, r;
        logic held, rose;

        Reset   = 1'b0;
        Run     = 1'b0;
        StepBtn = 1'b0;
        Clear   = 1'b0;
        StepAck = 1'b0;
        Rate    = 2'd0;
        steps(3);

        // Reset state.
        check("rst_stepreq", StepReq, 0);
        check("rst_running", Running, 0);
        check("rst_gen",     Gen,     0);
        check("rst_overrun", Overrun, 0);
        Reset = 1'b1;
        steps(2);
        check("idle_stepreq", StepReq, 0);

        // Free-run at Rate=0, ack delayed one cycle.
        Run = 1'b1;
        auto_ack = 1'b1;
        steps(2);
        check("run_sync_latency", Running, 0);
        step();
        check("running_set", Running, 1);
        t0 = cyc;
        wait_rise("req0", 10, r0);
        check("first_req_latency", r0 - t0, 4);
        wait_fall("fall0", 5, f);
        check("req_width", f - r0, 2);
        check("gen1", Gen, 1);
        wait_rise("req1", 10, r1);
        check("period_r0_a", r1 - r0, 4);
        wait_fall("fall1", 5, f);
        check("gen2", Gen, 2);
        wait_rise("req2", 10, r2);
        check("period_r0_b", r2 - r1, 4);
        wait_fall("fall2", 5, f);
        check("gen3", Gen, 3);
        check("no_overrun", Overrun, 0);

        // Rate=2, then drop back to Rate=0 with the counter at 10.
        Rate = 2'd2;
        wait_rise("req3", 30, r3);
        check("period_r2_a", r3 - r2, 16);
        wait_fall("fall3", 5, f);
        wait_rise("req4", 30, r4);
        check("period_r2_b", r4 - r3, 16);
        wait_fall("fall4", 5, f);
        check("gen5", Gen, 5);
        for (int i = 0; i < 20 && cyc < r4 + 10; i++) step();
        Rate = 2'd0;
        wait_rise("req5", 20, r5);
        check("rate_drop_tick", r5 - r4, 11);
        wait_fall("fall5", 5, f);
        wait_rise("req6", 10, r6);
        check("period_after_drop", r6 - r5, 4);

        // Stalled ack: request held, dropped ticks flag Overrun.
        auto_ack = 1'b0;
        StepAck  = 1'b0;
        steps(3);
        check("overrun_before_tick", Overrun, 0);
        step();
        check("overrun_set", Overrun, 1);
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            held &= StepReq;
        end
        check("req_held_stall", held, 1);
        check("gen_stall", Gen, 6);
        StepAck = 1'b1;
        step();
        StepAck = 1'b0;
        check("ack_release", StepReq, 0);
        check("gen_after_stall", Gen, 7);
        check("overrun_sticky", Overrun, 1);

        // Run falls while a request is outstanding.
        wait_rise("req7", 10, r7);
        check("tick_grid_kept", r7 - r6, 12);
        Run = 1'b0;
        steps(4);
        check("req_held_run_fall", StepReq, 1);
        check("running_in_req", Running, 1);
        StepAck = 1'b1;
        step();
        StepAck = 1'b0;
        check("ack_after_run_fall", StepReq, 0);
        check("gen_after_run_fall", Gen, 8);
        check("stopped_after_ack", Running, 0);
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (StepReq) rose = 1'b1;
        end
        check("no_req_when_stopped", rose, 0);

        // Single step from the button, held for 5 cycles.
        c0 = cyc;
        StepBtn = 1'b1;
        wait_rise("btn_req", 8, rb);
        check("btn_latency", rb - c0, 3);
        check("single_not_running", Running, 0);
        StepAck = 1'b1;
        step();
        StepAck = 1'b0;
        check("btn_ack", StepReq, 0);
        check("gen_btn1", Gen, 9);
        step();
        StepBtn = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (StepReq) rose = 1'b1;
        end
        check("one_req_per_press", rose, 0);
        check("stays_stopped", Running, 0);
        StepBtn = 1'b1;
        wait_rise("btn_req2", 8, rb);
        StepAck = 1'b1;
        step();
        StepAck = 1'b0;
        StepBtn = 1'b0;
        check("gen_btn2", Gen, 10);

        // Clear coincident with StepAck.
        steps(4);
        check("pre_clear_overrun", Overrun, 1);
        check("pre_clear_gen", Gen, 10);
        StepBtn = 1'b1;
        wait_rise("btn_req3", 8, rb);
        StepAck = 1'b1;
        Clear   = 1'b1;
        step();
        check("clear_stepreq", StepReq, 0);
        check("clear_gen",     Gen,     0);
        check("clear_overrun", Overrun, 0);
        check("clear_running", Running, 0);
        Clear   = 1'b0;
        StepAck = 1'b0;
        StepBtn = 1'b0;
        steps(4);
        check("clear_no_req", StepReq, 0);

        // Generation counter wrap (GEN_W=4).
        Run = 1'b1;
        auto_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_rise("wrap_req", 20, r);
            wait_fall("wrap_fall", 6, f);
            if (i == 14) check("gen_15", Gen, 15);
        end
        check("gen_wrap", Gen, 0);
        check("wrap_no_overrun", Overrun, 0);

        // Asynchronous reset in the middle of a stalled request.
        wait_rise("pre_rst_req", 10, r);
        wait_fall("pre_rst_fall", 6, f);
        wait_rise("pre_rst_req2", 10, r);
        auto_ack = 1'b0;
        StepAck  = 1'b0;
        steps(5);
        check("pre_rst_overrun", Overrun, 1);
        check("pre_rst_gen", Gen, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_stepreq", StepReq, 0);
        check("arst_running", Running, 0);
        check("arst_gen",     Gen,     0);
        check("arst_overrun", Overrun, 0);
        steps(2);
        Reset = 1'b1;
        t0 = cyc;
        auto_ack = 1'b1;
        wait_rise("restart_req", 12, r);
        check("restart_latency", r - t0, 7);
        check("restart_running", Running, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sim_step_scheduler.md
Name: sim_step_scheduler

Overview:
Sequences generation updates of the 8x8x8 cell simulator. Produces a rate-controlled step request while running, a single-step request from a button while stopped, and tracks the generation count. Sits between the board controls (switches/buttons) and the cell-update datapath. Uses a req/ack handshake so the datapath may take one or more cycles per generation.

Parameters:
BASE_PERIOD, 1562500, clocks per step at Rate=0 (16 Hz at 25 MHz); must be >= 2
CNT_W, 24, tick counter width; must hold BASE_PERIOD<<3
GEN_W, 16, generation counter width

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Run  in  1  async level (switch): 1 = free-run, 0 = stopped
StepBtn  in  1  async level (button): single-step when stopped
Rate  in  2  step period select: period = BASE_PERIOD << Rate
Clear  in  1  synchronous, active-high: abort and return to stopped, zero counters
StepReq  out  1  request one generation update; held until acknowledged
StepAck  in  1  datapath completed the generation (sampled high while StepReq=1)
Running  out  1  1 when state is S_RUN, or S_REQ entered from S_RUN
Gen  out  GEN_W  completed-generation count
Overrun  out  1  sticky: a rate tick arrived while a request was outstanding

Behaviour:
- Reset (async, Reset=0): state S_STOP; StepReq=0, Running=0, Gen=0, Overrun=0, tick counter=0, synchronizer flops=0, single flag=0.
- Run and StepBtn pass through 2-flop synchronizers (2-cycle latency); StepBtn rising edge detected on the synchronized value (one-cycle pulse btn_rise).
- Tick counter: counts while Run_s=1 and state is S_RUN or S_REQ. When cnt >= (BASE_PERIOD<<Rate)-1: tick=1 for one cycle, cnt<=0. Otherwise cnt<=cnt+1. Using >= means a Rate decrease mid-count ticks on the next cycle. In S_STOP, cnt<=0.
- States:
  - S_STOP: if Run_s, go S_RUN. Else if btn_rise, set single=1, StepReq<=1, go S_REQ.
  - S_RUN: if !Run_s, go S_STOP. Else if tick, single=0, StepReq<=1, go S_REQ.
  - S_REQ: StepReq=1. If StepAck: StepReq<=0, Gen<=Gen+1 (wraps all-ones to 0). Next state is S_RUN if single=0 and Run_s=1, else S_STOP. A tick while in S_REQ sets Overrun=1; the tick is dropped, not queued.
- StepAck outside S_REQ is ignored. btn_rise outside S_STOP is ignored.
- Run_s falling during S_REQ: the request stays asserted until acked, then the FSM goes to S_STOP (no abandoned handshake).
- Run_s rising during a single-step S_REQ: after ack, go S_STOP; the next cycle then goes to S_RUN.
- StepReq rises at most once per completed handshake. The minimum spacing between request rising edges is 2 cycles (req, ack).
- Clear (synchronous, highest priority, any state):
  - next cycle: state S_STOP, StepReq=0, Gen=0, Overrun=0, cnt=0, single=0
  - a simultaneous StepAck is discarded (Gen stays 0)
  - synchronizers are unaffected
- Reset deasserting mid-operation: normal restart from S_STOP. Run held high gives the first StepReq BASE_PERIOD<<Rate cycles after Run_s is seen.
- Running: registered, reflects next-state as defined in Ports.

Test Plan:
- BASE_PERIOD=4, Rate=0, Run=1, StepAck = StepReq delayed 1 cycle -> StepReq pulses (2 cycles each) with rising edges every 4 cycles; Gen=1,2,3 after three handshakes; Overrun=0.
- Same setup, Rate=2 -> rising edges every 16 cycles; switch Rate 2->0 when cnt=10 -> tick on the next cycle, then every 4 cycles.
- Run=1, Rate=0, StepAck held low for 10 cycles -> StepReq stays 1 throughout, Overrun=1 after the first dropped tick, Gen increments only once on ack.
- Run=0, pulse StepBtn once (held 5 cycles) -> exactly one StepReq; after ack Gen=1, state S_STOP, Running=0; a second press gives Gen=2.
- Run=1 with StepReq outstanding, then Run=0 before ack -> StepReq held until StepAck, Gen increments, then S_STOP; no further requests.
- Clear asserted in the same cycle as StepAck with Gen=5, Overrun=1 -> next cycle StepReq=0, Gen=0, Overrun=0, Running=0; Reset low mid-request -> all outputs 0 immediately.
